// File: rtl/hex_scroll_ctrl.sv
// Six-digit scrolling message display: an 8-entry pattern buffer written from switches,
// shown on HEX5..HEX0 starting at a rotating offset that advances every TICK_DIV cycles.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | scrolling paused, offset held, divider held at 0
// RUN   | divider counting, offset advances at each divider wrap
module hex_scroll_ctrl #(
  parameter int TICK_DIV = 25000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [1:0] KEY,
  input  logic [9:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [9:0] LEDR
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [6:0]       BLANK    = 7'h7F;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [1:0]       key_s1;
  logic [1:0]       key_s2;
  logic [1:0]       key_prev;
  logic [1:0]       press_q;
  logic             wr_pulse;
  logic             tgl_pulse;

  logic [6:0]       msg_buf [8];
  logic [2:0]       wr_addr;
  logic [6:0]       wr_data;

  state_t           state_q;
  state_t           state_d;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic [2:0]       off_q;
  logic [2:0]       off_d;

  // Buttons idle high; flops reset to 1 so a key held through reset looks like a fresh press.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      key_s1   <= 2'b11;
      key_s2   <= 2'b11;
      key_prev <= 2'b11;
      press_q  <= 2'b00;
    end else begin
      key_s1   <= KEY;
      key_s2   <= key_s1;
      key_prev <= key_s2;
      press_q  <= key_prev & ~key_s2;
    end
  end

  assign wr_pulse  = press_q[1];
  assign tgl_pulse = press_q[0];

  assign wr_addr = SW[9:7];
  assign wr_data = SW[6:0];

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 8; i++) begin
        msg_buf[i] <= BLANK;
      end
    end else if (wr_pulse) begin
      msg_buf[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      div_q   <= '0;
      off_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      off_q   <= off_d;
    end
  end

  // A pause landing on the terminal count takes priority over the step.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    off_d   = off_q;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (tgl_pulse) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (tgl_pulse) begin
          state_d = IDLE;
          div_d   = '0;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          off_d = off_q + 3'd1;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
      end
    endcase
  end

  // Index arithmetic is 3 bits wide so the window wraps around the buffer for free.
  assign HEX5 = msg_buf[off_q];
  assign HEX4 = msg_buf[off_q + 3'd1];
  assign HEX3 = msg_buf[off_q + 3'd2];
  assign HEX2 = msg_buf[off_q + 3'd3];
  assign HEX1 = msg_buf[off_q + 3'd4];
  assign HEX0 = msg_buf[off_q + 3'd5];

  assign LEDR = {(state_q == RUN), 6'b000000, off_q};

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Bench for hex_scroll_ctrl: directed scenarios plus random key/switch traffic, all
// compared each cycle against an event-scheduling reference model of the display.
module tb_hex_scroll_ctrl;

  localparam int TD = 4;

  logic       CLOCK_50 = 1'b0;
  logic       RESET;
  logic [1:0] KEY;
  logic [9:0] SW;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [9:0] LEDR;
  logic [6:0] hex_a [6];

  hex_scroll_ctrl #(.TICK_DIV(TD)) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .KEY(KEY), .SW(SW),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
    .LEDR(LEDR)
  );

  assign hex_a[0] = HEX0;
  assign hex_a[1] = HEX1;
  assign hex_a[2] = HEX2;
  assign hex_a[3] = HEX3;
  assign hex_a[4] = HEX4;
  assign hex_a[5] = HEX5;

  always #5 CLOCK_50 = ~CLOCK_50;

  int ncmp = 0;
  int nerr = 0;

  // Reference model: a press is a sampled 1->0 and takes effect 3 edges later.
  int         mcyc, mstart, moff;
  bit         mrun, mlast0, mlast1, m_t, m_w, m_st;
  logic [6:0] mbuf [8];
  int         q0[$];
  int         q1[$];

  task automatic model_reset();
    mcyc = 0; mstart = 0; moff = 0; mrun = 1'b0;
    mlast0 = 1'b1; mlast1 = 1'b1;
    foreach (mbuf[i]) mbuf[i] = 7'h7F;
    q0.delete(); q1.delete();
  endtask

  task automatic model_step();
    mcyc++;
    m_t = (q0.size() > 0) && (q0[0] == mcyc);
    if (m_t) void'(q0.pop_front());
    m_w = (q1.size() > 0) && (q1[0] == mcyc);
    if (m_w) void'(q1.pop_front());
    m_st = mrun && !m_t && ((mcyc - mstart) % TD == 0);
    if (m_st) moff = (moff + 1) % 8;
    if (m_t) begin mrun = !mrun; mstart = mcyc; end
    if (m_w) mbuf[SW[9:7]] = SW[6:0];
    if (mlast0 && !KEY[0]) q0.push_back(mcyc + 3);
    if (mlast1 && !KEY[1]) q1.push_back(mcyc + 3);
    mlast0 = KEY[0];
    mlast1 = KEY[1];
  endtask

  initial forever begin
    @(posedge CLOCK_50);
    if (!RESET) model_step();
  end

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 6; k++)
      chk($sformatf("HEX%0d", k), 10'(hex_a[k]), 10'(mbuf[3'(moff + 5 - k)]));
    chk("LEDR", LEDR, {mrun, 6'b000000, 3'(moff)});
  endtask

  task automatic tick();
    @(negedge CLOCK_50);
    check_all();
  endtask

  task automatic press_write(input logic [2:0] a, input logic [6:0] v);
    SW = {a, v}; KEY[1] = 1'b0;
    tick(); tick();
    KEY[1] = 1'b1;
    tick(); tick();
  endtask

  task automatic press_toggle();
    KEY[0] = 1'b0;
    tick(); tick();
    KEY[0] = 1'b1;
    tick(); tick();
  endtask

  task automatic align_step();
    for (int i = 0; i < TD && ((mcyc - mstart) % TD) != 0; i++) tick();
  endtask

  int         steps, last, cyc, pos;
  logic [2:0] prev_off, off_b, addr;
  logic [6:0] v;
  logic [6:0] vals [20];

  initial begin
    RESET = 1'b1; KEY = 2'b11; SW = 10'h000;
    model_reset();
    #1;
    for (int k = 0; k < 6; k++) chk("rst_hex", 10'(hex_a[k]), 10'h07F);
    chk("rst_ledr", LEDR, 10'h000);
    repeat (3) tick();
    RESET = 1'b0;

    // Single write, exact latency
    SW = {3'd0, 7'h40}; KEY[1] = 1'b0;
    for (int e = 0; e < 3; e++) begin
      tick();
      chk("wr_early_hex5", 10'(HEX5), 10'h07F);
    end
    tick();
    chk("wr_hex5", 10'(HEX5), 10'h040);
    for (int k = 0; k < 5; k++) chk("wr_other_hex", 10'(hex_a[k]), 10'h07F);
    chk("wr_idle", 10'(LEDR[9]), 10'h000);
    KEY[1] = 1'b1;
    tick();

    // Fill buffer and scroll a full lap
    for (int a = 0; a < 8; a++) press_write(3'(a), 7'(a));
    press_toggle();
    chk("run_flag", 10'(LEDR[9]), 10'h001);
    steps = 0; last = -1; cyc = 0; prev_off = LEDR[2:0];
    for (int i = 0; i < 60 && steps < 8; i++) begin
      tick(); cyc++;
      if (LEDR[2:0] !== prev_off) begin
        steps++;
        if (last >= 0) chk("step_period", 10'(cyc - last), 10'd4);
        last = cyc; prev_off = LEDR[2:0];
        if (LEDR[2:0] == 3'd3) chk("wrap_hex0", 10'(HEX0), 10'h000);
      end
    end
    chk("lap_steps", 10'(steps), 10'd8);
    chk("lap_off", 10'(LEDR[2:0]), 10'd0);
    chk("lap_hex5", 10'(HEX5), 10'h000);

    // Pause landing on terminal count, then re-entry timing
    align_step();
    off_b = LEDR[2:0];
    KEY[0] = 1'b0; tick(); tick(); KEY[0] = 1'b1; tick(); tick();
    chk("pause_flag", 10'(LEDR[9]), 10'h000);
    chk("pause_off", 10'(LEDR[2:0]), 10'(off_b));
    repeat (5) tick();
    chk("pause_hold", 10'(LEDR[2:0]), 10'(off_b));
    KEY[0] = 1'b0; tick(); tick(); KEY[0] = 1'b1; tick(); tick();
    chk("resume_flag", 10'(LEDR[9]), 10'h001);
    tick(); tick(); tick();
    chk("resume_pre", 10'(LEDR[2:0]), 10'(off_b));
    tick();
    chk("resume_step", 10'(LEDR[2:0]), 10'(3'(off_b + 3'd1)));

    // Write coinciding with a step
    align_step();
    off_b = LEDR[2:0];
    addr = 3'(moff + 5);
    v = 7'($urandom);
    SW = {addr, v}; KEY[1] = 1'b0; tick(); tick(); KEY[1] = 1'b1; tick(); tick();
    chk("stepwr_hex1", 10'(HEX1), 10'(v));
    chk("stepwr_off", 10'(LEDR[2:0]), 10'(3'(off_b + 3'd1)));

    // Long hold with changing switches: single write of value at the write edge
    press_toggle();
    chk("hold_idle", 10'(LEDR[9]), 10'h000);
    pos = $urandom_range(0, 5);
    addr = 3'(moff + pos);
    for (int i = 0; i < 20; i++) begin
      SW = {addr, 7'($urandom)};
      vals[i] = SW[6:0];
      if (i == 0) KEY[1] = 1'b0;
      tick();
    end
    KEY[1] = 1'b1;
    tick(); tick();
    chk("hold_value", 10'(hex_a[5 - pos]), 10'(vals[3]));

    // Simultaneous toggle and write
    pos = $urandom_range(0, 5);
    addr = 3'(moff + pos);
    v = 7'($urandom);
    SW = {addr, v}; KEY = 2'b00; tick(); tick(); KEY = 2'b11; tick(); tick();
    chk("both_run", 10'(LEDR[9]), 10'h001);
    chk("both_wr", 10'(hex_a[5 - pos]), 10'(v));

    // Asynchronous reset mid-run
    repeat (6) tick();
    @(posedge CLOCK_50);
    #3;
    RESET = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 6; k++) chk("async_hex", 10'(hex_a[k]), 10'h07F);
    chk("async_ledr", LEDR, 10'h000);
    tick(); tick();
    RESET = 1'b0;
    repeat (6) tick();
    chk("post_rst_ledr", LEDR, 10'h000);

    // Key held low through reset release
    KEY[0] = 1'b0; RESET = 1'b1; model_reset();
    tick(); tick();
    RESET = 1'b0;
    tick(); tick(); tick();
    chk("held_pre", 10'(LEDR[9]), 10'h000);
    tick();
    chk("held_press", 10'(LEDR[9]), 10'h001);
    KEY[0] = 1'b1;
    tick(); tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      SW = 10'($urandom);
      if ($urandom_range(0, 7) == 0) KEY[0] = ~KEY[0];
      if ($urandom_range(0, 3) == 0) KEY[1] = ~KEY[1];
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/hex_scroll_ctrl.md
HEX_SCROLL_CTRL -- requirements
Module: hex_scroll_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 25000000, SHALL set the clock cycles per scroll step; legal range 2 to 2^25.
REQ-002 CLOCK_50  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-003 RESET  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 KEY  input  2  SHALL be the active-low pushbuttons: KEY[1] is buffer write strobe, KEY[0] is run/pause toggle.
REQ-005 SW  input  10  SHALL carry the write address on SW[9:7] and the segment pattern on SW[6:0].
REQ-006 HEX0..HEX5  output  7 each  SHALL drive the six displays with stored patterns, unmodified; HEX5 is leftmost.
REQ-007 LEDR  output  10  SHALL show status: LEDR[9] run flag, LEDR[8:3] zero, LEDR[2:0] scroll offset.

Function
REQ-008 Message buffer SHALL hold 8 entries of 7 bits, addressed 0-7; every SW[9:7] value is valid.
REQ-009 KEY[1] and KEY[0] SHALL each pass through a 2-flop synchronizer plus a previous-value register.
REQ-010 A press SHALL be a synchronized 1->0 transition and SHALL yield a single one-cycle pulse per press; holding or releasing a key SHALL yield no further pulses.
REQ-011 A KEY[1] press SHALL write SW[6:0] into entry SW[9:7] at the 3rd rising edge after the first edge that samples KEY[1]=0; SW sampled at that edge.
REQ-012 HEX outputs SHALL be combinational from buffer and offset: HEX5=buf[off], HEX4=buf[off+1], HEX3=buf[off+2], HEX2=buf[off+3], HEX1=buf[off+4], HEX0=buf[off+5], indices mod 8.
REQ-013 FSM SHALL have two states: IDLE (offset held, divider held at 0) and RUN (divider counting).
REQ-014 A KEY[0] press SHALL toggle IDLE<->RUN with the same 3-edge latency as REQ-011.
REQ-015 In RUN the divider SHALL count 0..TICK_DIV-1; at TICK_DIV-1 it SHALL wrap to 0 and offset SHALL increment by 1 on the same edge.
REQ-016 Offset SHALL be 3 bits and wrap 7->0 with no stall or skip.
REQ-017 RUN->IDLE transition SHALL clear the divider to 0; an IDLE->RUN transition SHALL start counting from 0, so the first step occurs TICK_DIV cycles after entry.
REQ-018 If RUN->IDLE coincides with divider terminal count, pause SHALL win: offset not incremented.
REQ-019 A write coinciding with a scroll step SHALL apply both; HEX outputs reflect new offset and new entry after that edge.
REQ-020 Writes SHALL be accepted in both states and SHALL NOT alter state, offset or divider.
REQ-021 Simultaneous KEY[0] and KEY[1] presses SHALL both take effect on the same edge.
REQ-022 LEDR[9] SHALL be 1 exactly when state is RUN.

Reset
REQ-023 RESET assertion SHALL immediately, without clock, set all buffer entries to 7'h7F, offset 0, divider 0, state IDLE, and all synchronizer and previous-value flops to 1.
REQ-024 During reset HEX0..HEX5 SHALL read 7'h7F and LEDR SHALL read 10'h000.
REQ-025 Key presses in progress at reset SHALL be discarded; a key held low through reset release SHALL register as a press one synchronizer latency later.
REQ-026 Reset asserted mid-RUN SHALL abort scrolling with no partial write or offset change after deassertion.

Verification (bench uses TICK_DIV=4)
REQ-027 Reset, write 7'h40 to addr 0 via KEY[1] pulse -> HEX5=7'h40 exactly 3 edges after first KEY[1]=0 sample; HEX4..HEX0=7'h7F; state IDLE.
REQ-028 Load entries 0-7 with 7'h00..7'h07, press KEY[0] -> LEDR[9]=1; offset steps every 4 cycles; after 8 steps LEDR[2:0]=0 and HEX5=7'h00 again; at offset 3 HEX0=7'h00 (wrap).
REQ-029 In RUN, press KEY[0] timed so toggle coincides with terminal count -> offset unchanged, LEDR[9]=0; re-press -> next step exactly 4 cycles after RUN entry.
REQ-030 In RUN, KEY[1] write to addr (off+5)%8 on a step edge -> both applied; HEX1 shows new pattern.
REQ-031 Hold KEY[1] low 20 cycles with SW changing -> exactly one write, of SW value at the write edge.
REQ-032 Assert RESET asynchronously mid-RUN, between clock edges -> all HEX=7'h7F and LEDR=0 before next edge; after release, state IDLE, offset 0.
